// File: rtl/dram_axi_id_remap.sv
// AXI4 ID remapper: folds wide SoC IDs onto narrow controller IDs via per-direction tables.
// Optional DRAM_ID_REMAP_STATS_EN adds stall counters and a read-table high-water mark.

package dram_axi_pkg;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;
    localparam int unsigned SlvIdW    = 6;
    localparam int unsigned MstIdW    = 4;

    typedef struct packed {
        logic [SlvIdW-1:0]    id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [UserWidth-1:0] user;
    } slv_ax_t;

    typedef struct packed {
        logic [MstIdW-1:0]    id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [UserWidth-1:0] user;
    } mst_ax_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_t;

    typedef struct packed {
        logic [SlvIdW-1:0]    id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } slv_b_t;

    typedef struct packed {
        logic [MstIdW-1:0]    id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } mst_b_t;

    typedef struct packed {
        logic [SlvIdW-1:0]    id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } slv_r_t;

    typedef struct packed {
        logic [MstIdW-1:0]    id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } mst_r_t;

    typedef struct packed {
        slv_ax_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        slv_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        slv_b_t b;
        logic   b_valid;
        slv_r_t r;
        logic   r_valid;
    } slv_resp_t;

    typedef struct packed {
        mst_ax_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        mst_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        mst_b_t b;
        logic   b_valid;
        mst_r_t r;
        logic   r_valid;
    } mst_resp_t;
endpackage

module dram_axi_id_table #(
    parameter int unsigned MaxTxns      = 8,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter int unsigned SlvIdWidth   = 6,
    parameter int unsigned MstIdWidth   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [SlvIdWidth-1:0] req_id,
    input  logic                  push,
    output logic                  can_accept,
    output logic [MstIdWidth-1:0] req_mst_id,
    input  logic [MstIdWidth-1:0] rsp_mst_id,
    input  logic                  rsp_valid,
    input  logic                  pop,
    output logic [SlvIdWidth-1:0] rsp_slv_id
`ifdef DRAM_ID_REMAP_STATS_EN
    ,
    output logic [MaxTxns-1:0]    valid_o
`endif
);
    localparam int unsigned IdxW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
    localparam int unsigned CntW = $clog2(MaxTxnsPerId + 1);

    logic [MaxTxns-1:0]    valid_q;
    logic [SlvIdWidth-1:0] id_q  [MaxTxns];
    logic [CntW-1:0]       cnt_q [MaxTxns];

    logic            hit, free;
    logic [IdxW-1:0] hit_idx, free_idx, sel_idx, rsp_idx;
    logic            rsp_hit;
    logic [MaxTxns-1:0] inc, dec;

    // Lookup: first matching entry, else lowest free entry; both from pre-cycle state
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            if (!hit && valid_q[i] && id_q[i] == req_id) begin
                hit     = 1'b1;
                hit_idx = IdxW'(i);
            end
            if (!free && !valid_q[i]) begin
                free     = 1'b1;
                free_idx = IdxW'(i);
            end
        end
        sel_idx    = hit ? hit_idx : free_idx;
        can_accept = hit ? (cnt_q[hit_idx] < CntW'(MaxTxnsPerId)) : free;
        req_mst_id = MstIdWidth'(sel_idx);
    end

    // Response side: controller ID indexes the table directly
    always_comb begin
        rsp_idx    = rsp_mst_id[IdxW-1:0];
        rsp_hit    = ({1'b0, rsp_mst_id} < (MstIdWidth+1)'(MaxTxns))
                     && valid_q[rsp_idx];
        rsp_slv_id = rsp_hit ? id_q[rsp_idx] : '0;
        for (int i = 0; i < MaxTxns; i++) begin
            inc[i] = push && (sel_idx == IdxW'(i));
            dec[i] = pop && rsp_hit && (rsp_idx == IdxW'(i));
        end
    end

    // Entry update: allocate/increment on accept, decrement/free on retire, hold when both
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < MaxTxns; i++) begin
                id_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MaxTxns; i++) begin
                if (inc[i] && !dec[i]) begin
                    if (!valid_q[i]) begin
                        valid_q[i] <= 1'b1;
                        id_q[i]    <= req_id;
                        cnt_q[i]   <= CntW'(1);
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntW'(1);
                    end
                end else if (dec[i] && !inc[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                    if (cnt_q[i] == CntW'(1)) valid_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DRAM_ID_REMAP_STATS_EN
    assign valid_o = valid_q;
`endif

    // A response must always name an entry that is in flight
    a_rsp_known: assert property (
        @(posedge clk_i) disable iff (!rst_ni) rsp_valid |-> rsp_hit
    );
endmodule

module dram_axi_id_remap #(
    parameter int unsigned SlvIdWidth   = 6,
    parameter int unsigned MstIdWidth   = 4,
    parameter int unsigned MaxTxns      = 8,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter type slv_req_t  = dram_axi_pkg::slv_req_t,
    parameter type slv_resp_t = dram_axi_pkg::slv_resp_t,
    parameter type mst_req_t  = dram_axi_pkg::mst_req_t,
    parameter type mst_resp_t = dram_axi_pkg::mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
`ifdef DRAM_ID_REMAP_STATS_EN
    ,
    output logic [31:0]                    stall_aw_o,
    output logic [31:0]                    stall_ar_o,
    output logic [$clog2(MaxTxns+1)-1:0]   max_inflight_o
`endif
);
    if (MaxTxns > 2**MstIdWidth) begin : g_bad_cfg
        $error("MaxTxns does not fit in MstIdWidth");
    end

    logic                  aw_can, ar_can;
    logic [MstIdWidth-1:0] aw_mid, ar_mid;
    logic [SlvIdWidth-1:0] b_sid, r_sid;
    logic                  aw_push, ar_push, b_pop, r_pop;

    assign aw_push = rst_ni & slv_req_i.aw_valid & mst_resp_i.aw_ready & aw_can;
    assign ar_push = rst_ni & slv_req_i.ar_valid & mst_resp_i.ar_ready & ar_can;
    assign b_pop   = rst_ni & mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_pop   = rst_ni & mst_resp_i.r_valid & slv_req_i.r_ready
                     & mst_resp_i.r.last;

`ifdef DRAM_ID_REMAP_STATS_EN
    logic [MaxTxns-1:0] rd_valid;
    logic [MaxTxns-1:0] wr_valid;
`endif

    dram_axi_id_table #(
        .MaxTxns     (MaxTxns),
        .MaxTxnsPerId(MaxTxnsPerId),
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth)
    ) u_wr_tbl (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_id    (slv_req_i.aw.id),
        .push      (aw_push),
        .can_accept(aw_can),
        .req_mst_id(aw_mid),
        .rsp_mst_id(mst_resp_i.b.id),
        .rsp_valid (mst_resp_i.b_valid),
        .pop       (b_pop),
        .rsp_slv_id(b_sid)
`ifdef DRAM_ID_REMAP_STATS_EN
        ,
        .valid_o   (wr_valid)
`endif
    );

    dram_axi_id_table #(
        .MaxTxns     (MaxTxns),
        .MaxTxnsPerId(MaxTxnsPerId),
        .SlvIdWidth  (SlvIdWidth),
        .MstIdWidth  (MstIdWidth)
    ) u_rd_tbl (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_id    (slv_req_i.ar.id),
        .push      (ar_push),
        .can_accept(ar_can),
        .req_mst_id(ar_mid),
        .rsp_mst_id(mst_resp_i.r.id),
        .rsp_valid (mst_resp_i.r_valid),
        .pop       (r_pop),
        .rsp_slv_id(r_sid)
`ifdef DRAM_ID_REMAP_STATS_EN
        ,
        .valid_o   (rd_valid)
`endif
    );

    // Controller-side request: payload copied, IDs swapped, handshakes gated
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.id    = aw_mid;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.size  = slv_req_i.aw.size;
        mst_req_o.aw.burst = slv_req_i.aw.burst;
        mst_req_o.aw.lock  = slv_req_i.aw.lock;
        mst_req_o.aw.cache = slv_req_i.aw.cache;
        mst_req_o.aw.prot  = slv_req_i.aw.prot;
        mst_req_o.aw.qos   = slv_req_i.aw.qos;
        mst_req_o.aw.user  = slv_req_i.aw.user;
        mst_req_o.aw_valid = rst_ni & slv_req_i.aw_valid & aw_can;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = rst_ni & slv_req_i.w_valid;
        mst_req_o.b_ready  = rst_ni & slv_req_i.b_ready;
        mst_req_o.ar.id    = ar_mid;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar.size  = slv_req_i.ar.size;
        mst_req_o.ar.burst = slv_req_i.ar.burst;
        mst_req_o.ar.lock  = slv_req_i.ar.lock;
        mst_req_o.ar.cache = slv_req_i.ar.cache;
        mst_req_o.ar.prot  = slv_req_i.ar.prot;
        mst_req_o.ar.qos   = slv_req_i.ar.qos;
        mst_req_o.ar.user  = slv_req_i.ar.user;
        mst_req_o.ar_valid = rst_ni & slv_req_i.ar_valid & ar_can;
        mst_req_o.r_ready  = rst_ni & slv_req_i.r_ready;
    end

    // SoC-side response: original IDs restored from the tables
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = rst_ni & mst_resp_i.aw_ready & aw_can;
        slv_resp_o.ar_ready = rst_ni & mst_resp_i.ar_ready & ar_can;
        slv_resp_o.w_ready  = rst_ni & mst_resp_i.w_ready;
        slv_resp_o.b.id     = b_sid;
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b.user   = mst_resp_i.b.user;
        slv_resp_o.b_valid  = rst_ni & mst_resp_i.b_valid;
        slv_resp_o.r.id     = r_sid;
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r.user   = mst_resp_i.r.user;
        slv_resp_o.r_valid  = rst_ni & mst_resp_i.r_valid;
    end

`ifdef DRAM_ID_REMAP_STATS_EN
    localparam int unsigned OccW = $clog2(MaxTxns + 1);

    logic [OccW-1:0] rd_occ;
    logic            unused_wr;

    assign unused_wr = ^wr_valid;

    // Number of live read-table entries
    always_comb begin
        rd_occ = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            rd_occ = rd_occ + OccW'(rd_valid[i]);
        end
    end

    // Saturating stall counters and read occupancy high-water mark
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_aw_o     <= '0;
            stall_ar_o     <= '0;
            max_inflight_o <= '0;
        end else begin
            if (slv_req_i.aw_valid && !aw_can && stall_aw_o != '1)
                stall_aw_o <= stall_aw_o + 32'd1;
            if (slv_req_i.ar_valid && !ar_can && stall_ar_o != '1)
                stall_ar_o <= stall_ar_o + 32'd1;
            if (rd_occ > max_inflight_o)
                max_inflight_o <= rd_occ;
        end
    end
`endif
endmodule

// File: tb/tb_dram_axi_id_remap.sv
// Scoreboard bench for dram_axi_id_remap: stimulus pushes expected IDs,
// a negedge monitor pops and compares on every handshake.
module tb_dram_axi_id_remap;
    import dram_axi_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    slv_req_t  slv_req;
    slv_resp_t slv_resp;
    mst_req_t  mst_req;
    mst_resp_t mst_resp;

`ifdef DRAM_ID_REMAP_STATS_EN
    logic [31:0] stall_aw, stall_ar;
    logic [3:0]  max_inflight;
`endif

    dram_axi_id_remap dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp)
`ifdef DRAM_ID_REMAP_STATS_EN
        ,
        .stall_aw_o    (stall_aw),
        .stall_ar_o    (stall_ar),
        .max_inflight_o(max_inflight)
`endif
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
    } ax_exp_t;

    ax_exp_t    exp_aw[$];
    ax_exp_t    exp_ar[$];
    logic [5:0] exp_b[$];
    logic [5:0] exp_r[$];
    ax_exp_t    e;
    logic [5:0] es;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake with no expectation queued", name);
    endtask

    // Monitor: compare every handshake against the head of its queue
    always @(negedge clk) begin
        if (rst_ni) begin
            if (mst_req.aw_valid && mst_resp.aw_ready) begin
                if (exp_aw.size() == 0) miss("aw");
                else begin
                    e = exp_aw.pop_front();
                    chk("awid", 64'(mst_req.aw.id), 64'(e.id));
                    chk("awaddr", 64'(mst_req.aw.addr), 64'(e.addr));
                end
            end
            if (mst_req.ar_valid && mst_resp.ar_ready) begin
                if (exp_ar.size() == 0) miss("ar");
                else begin
                    e = exp_ar.pop_front();
                    chk("arid", 64'(mst_req.ar.id), 64'(e.id));
                    chk("araddr", 64'(mst_req.ar.addr), 64'(e.addr));
                end
            end
            if (slv_resp.b_valid && slv_req.b_ready) begin
                if (exp_b.size() == 0) miss("b");
                else begin
                    es = exp_b.pop_front();
                    chk("bid", 64'(slv_resp.b.id), 64'(es));
                end
            end
            if (slv_resp.r_valid && slv_req.r_ready) begin
                if (exp_r.size() == 0) miss("r");
                else begin
                    es = exp_r.pop_front();
                    chk("rid", 64'(slv_resp.r.id), 64'(es));
                end
            end
        end
    end

    task automatic set_ar(input logic [5:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
        slv_req.ar       = '0;
        slv_req.ar.id    = id;
        slv_req.ar.addr  = addr;
        slv_req.ar.len   = len;
        slv_req.ar.size  = 3'd3;
        slv_req.ar.burst = 2'd1;
        slv_req.ar_valid = 1'b1;
    endtask

    task automatic set_aw(input logic [5:0] id, input logic [31:0] addr);
        slv_req.aw       = '0;
        slv_req.aw.id    = id;
        slv_req.aw.addr  = addr;
        slv_req.aw.size  = 3'd3;
        slv_req.aw.burst = 2'd1;
        slv_req.aw_valid = 1'b1;
    endtask

    task automatic wait_ar(input string name);
        logic acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = slv_resp.ar_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        slv_req.ar_valid = 1'b0;
        chk(name, 64'(acc), 64'd1);
    endtask

    task automatic wait_aw(input string name);
        logic acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = slv_resp.aw_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        slv_req.aw_valid = 1'b0;
        chk(name, 64'(acc), 64'd1);
    endtask

    task automatic do_ar(input logic [5:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [3:0] mid);
        exp_ar.push_back('{mid, addr});
        set_ar(id, addr, len);
        wait_ar("ar_accept");
    endtask

    task automatic do_aw(input logic [5:0] id, input logic [31:0] addr,
                         input logic [3:0] mid);
        exp_aw.push_back('{mid, addr});
        set_aw(id, addr);
        wait_aw("aw_accept");
    endtask

    task automatic drive_r(input logic [3:0] mid, input logic last,
                           input logic [5:0] sid);
        exp_r.push_back(sid);
        mst_resp.r      = '0;
        mst_resp.r.id   = mid;
        mst_resp.r.last = last;
        mst_resp.r.data = 64'hD00D_0000 + 64'(mid);
        mst_resp.r_valid = 1'b1;
    endtask

    task automatic do_r(input logic [3:0] mid, input logic last,
                        input logic [5:0] sid);
        drive_r(mid, last, sid);
        @(posedge clk);
        #1;
        mst_resp.r_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [3:0] mid, input logic [5:0] sid);
        exp_b.push_back(sid);
        mst_resp.b    = '0;
        mst_resp.b.id = mid;
        mst_resp.b_valid = 1'b1;
    endtask

    task automatic do_b(input logic [3:0] mid, input logic [5:0] sid);
        drive_b(mid, sid);
        @(posedge clk);
        #1;
        mst_resp.b_valid = 1'b0;
    endtask

    task automatic chk_ar_stall(input string name);
        @(negedge clk);
        chk({name, "_ready"}, 64'(slv_resp.ar_ready), 64'd0);
        chk({name, "_valid"}, 64'(mst_req.ar_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_mst"}, 64'({mst_req.aw_valid, mst_req.ar_valid,
            mst_req.w_valid, mst_req.b_ready, mst_req.r_ready}), 64'd0);
        chk({name, "_slv"}, 64'({slv_resp.aw_ready, slv_resp.ar_ready,
            slv_resp.w_ready, slv_resp.b_valid, slv_resp.r_valid}), 64'd0);
    endtask

    task automatic drive_all_valid();
        slv_req.aw_valid  = 1'b1;
        slv_req.ar_valid  = 1'b1;
        slv_req.w_valid   = 1'b1;
        mst_resp.b_valid  = 1'b1;
        mst_resp.r_valid  = 1'b1;
    endtask

    task automatic clear_valid();
        slv_req.aw_valid  = 1'b0;
        slv_req.ar_valid  = 1'b0;
        slv_req.w_valid   = 1'b0;
        mst_resp.b_valid  = 1'b0;
        mst_resp.r_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;

        // Reset state: everything quiet even with live inputs
        drive_all_valid();
        #2;
        chk_quiet("reset_init");
        clear_valid();
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Single write round trip, table empty afterwards
        do_aw(6'h2A, 32'h1000, 4'd0);
        do_b(4'd0, 6'h2A);
        do_aw(6'h11, 32'h1040, 4'd0);
        do_b(4'd0, 6'h11);

        // Fill the read table, ninth ID stalls until an entry frees
        for (int i = 0; i < 8; i++)
            do_ar(6'h30 + 6'(i), 32'h2000 + 32'(i * 64), 8'd0, 4'(i));
        set_ar(6'h38, 32'h3000, 8'd0);
        exp_ar.push_back('{4'd3, 32'h3000});
        chk_ar_stall("ar_full");
        drive_r(4'd3, 1'b1, 6'h33);
        @(negedge clk);
        chk("ar_free_same_cycle", 64'(slv_resp.ar_ready), 64'd0);
        @(posedge clk);
        #1;
        mst_resp.r_valid = 1'b0;
        wait_ar("ar_reuse_next_cycle");
        for (int i = 0; i < 8; i++)
            do_r(4'(i), 1'b1, (i == 3) ? 6'h38 : 6'h30 + 6'(i));

        // Per-ID limit: four share arid 0, fifth waits for one retire
        for (int i = 0; i < 4; i++)
            do_ar(6'h05, 32'h4000 + 32'(i * 64), 8'd0, 4'd0);
        set_ar(6'h05, 32'h4100, 8'd0);
        exp_ar.push_back('{4'd0, 32'h4100});
        chk_ar_stall("ar_per_id");
        drive_r(4'd0, 1'b1, 6'h05);
        @(negedge clk);
        chk("ar_per_id_retire_cycle", 64'(slv_resp.ar_ready), 64'd0);
        @(posedge clk);
        #1;
        mst_resp.r_valid = 1'b0;
        wait_ar("ar_per_id_accept");
        for (int i = 0; i < 4; i++)
            do_r(4'd0, 1'b1, 6'h05);

        // Burst read: only the last beat retires
        do_ar(6'h19, 32'h5000, 8'd7, 4'd0);
        for (int i = 0; i < 7; i++)
            do_r(4'd0, 1'b0, 6'h19);
        do_r(4'd0, 1'b1, 6'h19);
        do_ar(6'h1A, 32'h5100, 8'd0, 4'd0);
        do_r(4'd0, 1'b1, 6'h1A);

        // Same-cycle accept and retire on one entry keeps it live
        do_aw(6'h0C, 32'h6000, 4'd0);
        set_aw(6'h0C, 32'h6040);
        exp_aw.push_back('{4'd0, 32'h6040});
        drive_b(4'd0, 6'h0C);
        @(negedge clk);
        chk("aw_same_cycle_ready", 64'(slv_resp.aw_ready), 64'd1);
        @(posedge clk);
        #1;
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b0;
        do_aw(6'h0D, 32'h6080, 4'd1);
        do_b(4'd0, 6'h0C);
        do_b(4'd1, 6'h0D);
        do_aw(6'h0E, 32'h60C0, 4'd0);
        do_b(4'd0, 6'h0E);

        // Asynchronous reset with reads in flight
        do_ar(6'h21, 32'h7000, 8'd3, 4'd0);
        do_ar(6'h22, 32'h7040, 8'd3, 4'd1);
        do_ar(6'h23, 32'h7080, 8'd3, 4'd2);
        #2;
        drive_all_valid();
        mst_resp.r.id = 4'd1;
        rst_ni = 1'b0;
        #1;
        chk_quiet("reset_mid");
        clear_valid();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        do_ar(6'h24, 32'h7100, 8'd0, 4'd0);
        do_r(4'd0, 1'b1, 6'h24);

        @(posedge clk);
        #1;
        chk("exp_queues_empty",
            64'(exp_aw.size() + exp_ar.size() + exp_b.size() + exp_r.size()),
            64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
